// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC/instruction-fetch stage with decode slices, jump commit,
//              misaligned-target and fetch-timeout detection.
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        JB_instr_i,
  input  logic        JALR_instr_i,
  input  logic [31:0] imm_ext_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] instr_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_b5_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o,
  output logic        retire_o,
  output logic [1:0]  err_code_o
);

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [1:0]  ERR_NONE     = 2'd0;
  localparam logic [1:0]  ERR_MISALIGN = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic        retire_q, retire_d;

  logic [31:0] target;
  logic        timeout_hit;

  // JALR takes priority over JB; JALR clears bit 0 of its target.
  always_comb begin
    if (JALR_instr_i) begin
      target = (rs1_data_i + imm_ext_i) & ~32'h1;
    end else if (JB_instr_i) begin
      target = pc_q + imm_ext_i;
    end else begin
      target = pc_q + 32'd4;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == (TIMEOUT - 32'd1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    retire_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          cnt_d   = 32'd0;
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_EXEC: begin
        if (!stall_i) begin
          if (target[1]) begin
            err_d   = ERR_MISALIGN;
            state_d = S_HALT;
          end else begin
            pc_d     = target;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      cnt_q    <= 32'd0;
      err_q    <= ERR_NONE;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      retire_q <= retire_d;
    end
  end

  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == S_EXEC);
  assign retire_o      = retire_q;
  assign err_code_o    = err_q;

  assign instr_o     = instr_q;
  assign op_o        = instr_q[6:0];
  assign funct3_o    = instr_q[14:12];
  assign funct7_b5_o = instr_q[30];
  assign rs1_o       = instr_q[19:15];
  assign rs2_o       = instr_q[24:20];
  assign rd_o        = instr_q[11:7];
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed + randomized checks of fetch_unit against a
//                 transaction-level PC/instruction model.
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        JB_instr_i = 1'b0;
  logic        JALR_instr_i = 1'b0;
  logic [31:0] imm_ext_i = 32'd0;
  logic [31:0] rs1_data_i = 32'd0;
  logic [31:0] instr_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_b5_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] pc_o, pc_plus4_o;
  logic        instr_valid_o, retire_o;
  logic [1:0]  err_code_o;

  fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .JB_instr_i(JB_instr_i), .JALR_instr_i(JALR_instr_i),
    .imm_ext_i(imm_ext_i), .rs1_data_i(rs1_data_i),
    .instr_o(instr_o), .op_o(op_o), .funct3_o(funct3_o), .funct7_b5_o(funct7_b5_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .instr_valid_o(instr_valid_o), .retire_o(retire_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC, held instruction, pending retire, halt.
  logic [31:0] pc_m;
  logic [31:0] instr_m;
  logic        exp_ret;
  logic [1:0]  err_m;
  logic        halted;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_decode();
    chk("instr", instr_o, instr_m);
    chk("op", {25'd0, op_o}, {25'd0, instr_m[6:0]});
    chk("funct3", {29'd0, funct3_o}, {29'd0, instr_m[14:12]});
    chk("funct7b5", {31'd0, funct7_b5_o}, {31'd0, instr_m[30]});
    chk("rs1", {27'd0, rs1_o}, {27'd0, instr_m[19:15]});
    chk("rs2", {27'd0, rs2_o}, {27'd0, instr_m[24:20]});
    chk("rd", {27'd0, rd_o}, {27'd0, instr_m[11:7]});
    chk("pc", pc_o, pc_m);
    chk("pc_plus4", pc_plus4_o, pc_m + 32'd4);
  endtask

  // Reset from any state, with a stale rvalid presented during IDLE.
  task automatic do_reset();
    rst_n_i = 1'b0;
    imem_rvalid_i = 1'($urandom);
    imem_rdata_i = $urandom;
    tick();
    pc_m = RESET_PC; instr_m = NOP; exp_ret = 1'b0; err_m = 2'd0; halted = 1'b0;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_retire", {31'd0, retire_o}, 32'd0);
    chk("rst_err", {30'd0, err_code_o}, 32'd0);
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_instr", instr_o, NOP);
    rst_n_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    chk("idle_drop_instr", instr_o, NOP);
    chk("idle_drop_valid", {31'd0, instr_valid_o}, 32'd0);
  endtask

  task automatic fetch(input int k, input logic [31:0] data);
    for (int i = 0; i <= k; i++) begin
      imem_rvalid_i = (i == k);
      imem_rdata_i  = (i == k) ? data : $urandom;
      chk("fetch_req", {31'd0, imem_req_o}, 32'd1);
      chk("fetch_addr", imem_addr_o, pc_m);
      chk("fetch_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("fetch_retire", {31'd0, retire_o}, {31'd0, exp_ret});
      exp_ret = 1'b0;
      tick();
    end
    imem_rvalid_i = 1'b0;
    instr_m = data;
    chk("exec_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("exec_req", {31'd0, imem_req_o}, 32'd0);
    chk_decode();
  endtask

  task automatic exec(input int nstall, input logic jb, input logic jalr,
                      input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] tgt;
    for (int i = 0; i < nstall; i++) begin
      stall_i = 1'b1;
      JB_instr_i = 1'($urandom); JALR_instr_i = 1'($urandom);
      imm_ext_i = $urandom; rs1_data_i = $urandom;
      tick();
      chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("stall_retire", {31'd0, retire_o}, 32'd0);
      chk("stall_pc", pc_o, pc_m);
      chk("stall_instr", instr_o, instr_m);
    end
    stall_i = 1'b0;
    JB_instr_i = jb; JALR_instr_i = jalr; imm_ext_i = imm; rs1_data_i = rs1;
    if (jalr)    tgt = (rs1 + imm) & ~32'h1;
    else if (jb) tgt = pc_m + imm;
    else         tgt = pc_m + 32'd4;
    tick();
    JB_instr_i = 1'b0; JALR_instr_i = 1'b0;
    if (tgt[1]) begin
      halted = 1'b1; err_m = 2'd1;
    end else begin
      pc_m = tgt; exp_ret = 1'b1;
    end
  endtask

  task automatic chk_halt(input int n);
    for (int i = 0; i < n; i++) begin
      imem_rvalid_i = 1'($urandom);
      chk("halt_req", {31'd0, imem_req_o}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("halt_retire", {31'd0, retire_o}, 32'd0);
      chk("halt_err", {30'd0, err_code_o}, {30'd0, err_m});
      chk("halt_pc", pc_o, pc_m);
      chk("halt_instr", instr_o, instr_m);
      tick();
    end
    imem_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] imm, rs1;
    tick();
    do_reset();

    // First instruction, zero-wait memory, then sequential commit.
    fetch(0, 32'h0050_0093);
    chk("addi_op", {25'd0, op_o}, 32'h13);
    chk("addi_rd", {27'd0, rd_o}, 32'd1);
    chk("addi_f3", {29'd0, funct3_o}, 32'd0);
    exec(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("commit_pc", pc_o, 32'd4);
    fetch(1, 32'h0000_0013);

    // Reach 0x100 via JALR, then JB backwards, then JALR beats JB.
    exec(0, 1'b0, 1'b1, 32'd0, 32'h100);
    fetch(0, $urandom);
    exec(0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
    chk("jb_back_addr", imem_addr_o, 32'hF8);
    fetch(2, $urandom);
    exec(3, 1'b1, 1'b1, 32'd4, 32'h2001);
    chk("jalr_win_addr", imem_addr_o, 32'h2004);
    fetch(0, $urandom);

    // PC wrap at the top of the address space.
    exec(0, 1'b0, 1'b1, 32'hC, 32'hFFFF_FFF0);
    fetch(0, $urandom);
    exec(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("wrap_addr", imem_addr_o, 32'h0);
    fetch(1, $urandom);

    // Misaligned JB target from 0x100.
    exec(0, 1'b0, 1'b1, 32'h0, 32'h100);
    fetch(0, $urandom);
    exec(1, 1'b1, 1'b0, 32'd2, 32'd0);
    chk_halt(4);
    chk("mis_err", {30'd0, err_code_o}, 32'd1);

    // Fetch timeout: four FETCH cycles with no response.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", {31'd0, imem_req_o}, 32'd1);
      chk("to_err", {30'd0, err_code_o}, 32'd0);
      tick();
    end
    err_m = 2'd2;
    chk_halt(3);
    do_reset();
    chk("restart_addr", imem_addr_o, RESET_PC);
    chk("restart_req", {31'd0, imem_req_o}, 32'd1);

    // Reset asserted mid-FETCH.
    fetch(0, $urandom);
    exec(0, 1'b0, 1'b0, 32'd0, 32'd0);
    fetch(1, $urandom);
    exec(0, 1'b0, 1'b0, 32'd0, 32'd0);
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      fetch($urandom_range(0, 2), $urandom);
      imm = $urandom & ~32'h3;
      rs1 = $urandom & ~32'h2;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'h2;
      exec($urandom_range(0, 2), 1'($urandom), 1'($urandom), imm, rs1);
      if (halted) begin
        chk_halt(2);
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
